// File: rtl/rv32_alu_pkg.sv
// Shared definitions for the logical-ALU arbiter: opsel encodings, FSM state and owner tag.
// Holds no logic apart from the opsel legality helper.
package rv32_alu_pkg;

  localparam logic [3:0] OPSEL_AND  = 4'd2;
  localparam logic [3:0] OPSEL_OR   = 4'd3;
  localparam logic [3:0] OPSEL_XOR  = 4'd4;
  localparam logic [3:0] OPSEL_ANDI = 4'd9;
  localparam logic [3:0] OPSEL_ORI  = 4'd10;
  localparam logic [3:0] OPSEL_XORI = 4'd11;

  typedef enum logic {
    ST_IDLE,
    ST_HOLD
  } arb_state_e;

  typedef enum logic {
    OWN_REQ0,
    OWN_REQ1
  } owner_e;

  function automatic logic opsel_legal(input logic [3:0] opsel);
    return opsel inside {OPSEL_AND, OPSEL_OR, OPSEL_XOR, OPSEL_ANDI, OPSEL_ORI, OPSEL_XORI};
  endfunction

endpackage

// File: rtl/rv32_alu_logical.sv
// Combinational AND/OR/XOR unit; register and immediate opsel forms behave identically.
// Any opsel it does not recognise produces a zero result.
module rv32_alu_logical
  import rv32_alu_pkg::*;
(
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  input  logic [3:0]  opsel_i,
  output logic [31:0] result_o
);

  always_comb begin
    result_o = '0;
    case (opsel_i)
      OPSEL_AND, OPSEL_ANDI: result_o = op_a_i & op_b_i;
      OPSEL_OR,  OPSEL_ORI:  result_o = op_a_i | op_b_i;
      OPSEL_XOR, OPSEL_XORI: result_o = op_a_i ^ op_b_i;
      default:               result_o = '0;
    endcase
  end

endmodule

// File: rtl/rv32_alu_arb.sv
// Two-port arbiter in front of one shared logical ALU with a single held-result slot and req1 aging.
// Define RV32_ALU_ARB_ILLEGAL_CHK_EN to flag responses produced from an illegal opsel.
module rv32_alu_arb
  import rv32_alu_pkg::*;
#(
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic [31:0] req0_opA,
  input  logic [31:0] req0_opB,
  input  logic [3:0]  req0_opsel,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_opA,
  input  logic [31:0] req1_opB,
  input  logic [3:0]  req1_opsel,
  output logic        req1_ready,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp_result,
  output logic        err_illegal
);

  localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIMIT);

  arb_state_e  state_q;
  owner_e      owner_q;
  logic [2:0]  starve_cnt_q, starve_cnt_d;
  logic [31:0] result_q;
  logic        rsp0_valid_q, rsp1_valid_q;

  logic        owner_rdy, can_grant, gnt0, gnt1, drain;
  logic [31:0] alu_a, alu_b, alu_res;
  logic [3:0]  alu_opsel;

  // Only the current owner's rsp_ready can free the slot; the other port's is ignored.
  always_comb begin
    owner_rdy = (owner_q == OWN_REQ1) ? rsp1_ready : rsp0_ready;
    can_grant = (state_q == ST_IDLE) || owner_rdy;
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (can_grant) begin
      if (req1_valid && (starve_cnt_q == STARVE_MAX || !req0_valid)) gnt1 = 1'b1;
      else if (req0_valid)                                         gnt0 = 1'b1;
    end
    drain = (state_q == ST_HOLD) && owner_rdy;
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!req1_valid || gnt1)          starve_cnt_d = '0;
    else if (starve_cnt_q != STARVE_MAX) starve_cnt_d = starve_cnt_q + 3'd1;
  end

  assign alu_a     = gnt1 ? req1_opA   : req0_opA;
  assign alu_b     = gnt1 ? req1_opB   : req0_opB;
  assign alu_opsel = gnt1 ? req1_opsel : req0_opsel;

  rv32_alu_logical u_alu (
    .op_a_i   (alu_a),
    .op_b_i   (alu_b),
    .opsel_i  (alu_opsel),
    .result_o (alu_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_REQ0;
      starve_cnt_q <= '0;
      result_q     <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      if (gnt0 || gnt1) begin
        state_q      <= ST_HOLD;
        owner_q      <= gnt1 ? OWN_REQ1 : OWN_REQ0;
        result_q     <= alu_res;
        rsp0_valid_q <= gnt0;
        rsp1_valid_q <= gnt1;
      end else if (drain) begin
        state_q      <= ST_IDLE;
        rsp0_valid_q <= 1'b0;
        rsp1_valid_q <= 1'b0;
      end
    end
  end

`ifdef RV32_ALU_ARB_ILLEGAL_CHK_EN
  logic err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             err_q <= 1'b0;
    else if (gnt0 || gnt1)  err_q <= !opsel_legal(alu_opsel);
    else if (drain)         err_q <= 1'b0;
  end

  assign err_illegal = err_q;
`else
  assign err_illegal = 1'b0;
`endif

  // Grants are combinational; masking with rst_n keeps them low throughout reset.
  assign req0_ready = gnt0 & rst_n;
  assign req1_ready = gnt1 & rst_n;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp_result = result_q;

endmodule

// File: tb/tb_rv32_alu_arb.sv
// Directed scoreboard bench for rv32_alu_arb: grants are checked per cycle, responses by a monitor.
module tb_rv32_alu_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_opA, req0_opB, req1_opA, req1_opB;
  logic [3:0]  req0_opsel, req1_opsel;
  logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [31:0] rsp_result;
  logic        err_illegal;

  rv32_alu_arb #(.STARVE_LIMIT(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req0_valid  (req0_valid),
    .req0_opA    (req0_opA),
    .req0_opB    (req0_opB),
    .req0_opsel  (req0_opsel),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_opA    (req1_opA),
    .req1_opB    (req1_opB),
    .req1_opsel  (req1_opsel),
    .req1_ready  (req1_ready),
    .rsp0_valid  (rsp0_valid),
    .rsp0_ready  (rsp0_ready),
    .rsp1_valid  (rsp1_valid),
    .rsp1_ready  (rsp1_ready),
    .rsp_result  (rsp_result),
    .err_illegal (err_illegal)
  );

  always #5 clk = ~clk;

`ifdef RV32_ALU_ARB_ILLEGAL_CHK_EN
  localparam logic ILL_ERR = 1'b1;
`else
  localparam logic ILL_ERR = 1'b0;
`endif

  typedef struct {
    logic        owner;
    logic [31:0] res;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp0_res, exp1_res;
  logic        exp0_err, exp1_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // One cycle: grants are judged mid-cycle, then inputs may change just after the next rising edge.
  task automatic step(input string name, input int exp_gnt);
    logic [1:0] want;
    exp_t       e;
    want = (exp_gnt == 0) ? 2'b01 : (exp_gnt == 1) ? 2'b10 : 2'b00;
    @(negedge clk);
    chk(name, {30'd0, req1_ready, req0_ready}, {30'd0, want});
    if (req0_ready) begin e.owner = 1'b0; e.res = exp0_res; e.err = exp0_err; sb.push_back(e); end
    if (req1_ready) begin e.owner = 1'b1; e.res = exp1_res; e.err = exp1_err; sb.push_back(e); end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (rsp0_valid && rsp1_valid) begin
        vectors++; miscompares++;
        $display("FAIL rsp_both_valid: got 1, expected 0");
      end
      if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
        if (sb.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL rsp_unexpected: got result %h with empty scoreboard, expected none", rsp_result);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("rsp_owner",  {31'd0, rsp1_valid}, {31'd0, e.owner});
          chk("rsp_result", rsp_result, e.res);
          chk("rsp_err",    {31'd0, err_illegal}, {31'd0, e.err});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_opA = 32'hF0F0_F0F0; req0_opB = 32'h0FF0_0FF0; req0_opsel = 4'd2;
    req1_valid = 1'b1; req1_opA = '0; req1_opB = '0; req1_opsel = 4'd3;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    exp0_res = 32'h00F0_00F0; exp0_err = 1'b0; exp1_res = '0; exp1_err = 1'b0;
    #3;
    chk("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
    chk("rst_req1_ready", {31'd0, req1_ready}, 32'd0);
    chk("rst_rsp_valid",  {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    chk("rst_result",     rsp_result, 32'd0);
    chk("rst_err",        {31'd0, err_illegal}, 32'd0);

    // First grant on the first edge after release; AND register form.
    #14;
    rst_n = 1'b1;
    req1_valid = 1'b0;
    step("first_grant", 0);
    req0_valid = 1'b0;
    step("first_drain", -1);

    // Aging: with both requesting every cycle, req1 wins every fourth grant.
    req0_valid = 1'b1; req0_opA = 32'h0000_FFFF; req0_opB = 32'h00FF_00FF; req0_opsel = 4'd3;
    exp0_res = 32'h00FF_FFFF; exp0_err = 1'b0;
    req1_valid = 1'b1; req1_opA = 32'h1234_5678; req1_opB = 32'hFFFF_0000; req1_opsel = 4'd9;
    exp1_res = 32'h1234_0000; exp1_err = 1'b0;
    for (int i = 0; i < 8; i++) step($sformatf("aging_%0d", i), (i % 4 == 3) ? 1 : 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    step("aging_drain", -1);

    // req1 result held while its owner stalls; req0's rsp_ready must not free the slot.
    req1_valid = 1'b1; req1_opA = 32'hFFFF_0000; req1_opB = 32'h00FF_FF00; req1_opsel = 4'd11;
    exp1_res = 32'hFF00_FF00; exp1_err = 1'b0;
    rsp1_ready = 1'b0; rsp0_ready = 1'b1;
    step("hold1_grant", 1);
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_opA = 32'hAAAA_AAAA; req0_opB = 32'h5555_5555; req0_opsel = 4'd4;
    exp0_res = 32'hFFFF_FFFF; exp0_err = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step($sformatf("hold1_block_%0d", i), -1);
      chk("hold1_result", rsp_result, 32'hFF00_FF00);
      chk("hold1_valid",  {31'd0, rsp1_valid}, 32'd1);
    end
    rsp1_ready = 1'b1;
    step("hold1_refill", 0);
    req0_valid = 1'b0;
    step("hold1_drain", -1);

    // req1 aging keeps counting while blocked behind a held req0 result.
    req0_valid = 1'b1; req0_opA = 32'h0000_0001; req0_opB = 32'h0000_0003; req0_opsel = 4'd2;
    exp0_res = 32'h0000_0001; exp0_err = 1'b0;
    step("starve_g0", 0);
    rsp0_ready = 1'b0;
    req0_opA = 32'h0000_0010; req0_opB = 32'h0000_0001; req0_opsel = 4'd3;
    exp0_res = 32'h0000_0011;
    req1_valid = 1'b1; req1_opA = 32'h0000_000F; req1_opB = 32'h0000_0001; req1_opsel = 4'd4;
    exp1_res = 32'h0000_000E; exp1_err = 1'b0;
    for (int i = 0; i < 3; i++) step($sformatf("starve_block_%0d", i), -1);
    rsp0_ready = 1'b1;
    step("starve_win1", 1);
    req1_valid = 1'b0;
    step("starve_then0", 0);
    req0_valid = 1'b0;
    step("starve_drain", -1);

    // Non-owner ready must not release a req0-owned slot.
    req0_valid = 1'b1; req0_opA = 32'h0000_0001; req0_opB = 32'h8000_0000; req0_opsel = 4'd10;
    exp0_res = 32'h8000_0001; exp0_err = 1'b0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b1;
    step("own0_grant", 0);
    req0_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step($sformatf("own0_hold_%0d", i), -1);
      chk("own0_valid",  {31'd0, rsp0_valid}, 32'd1);
      chk("own0_result", rsp_result, 32'h8000_0001);
    end
    rsp0_ready = 1'b1;
    step("own0_drain", -1);
    chk("own0_released", {31'd0, rsp0_valid}, 32'd0);

    // Illegal opsel is still granted and returns zero.
    req0_valid = 1'b1; req0_opA = 32'hFFFF_FFFF; req0_opB = 32'hFFFF_FFFF; req0_opsel = 4'd7;
    exp0_res = 32'h0000_0000; exp0_err = ILL_ERR;
    step("illegal_grant", 0);
    req0_valid = 1'b0;
    step("illegal_drain", -1);

    // Reset during HOLD discards the held result at once.
    req0_valid = 1'b1; req0_opA = 32'h1234_5678; req0_opB = 32'hFFFF_FFFF; req0_opsel = 4'd4;
    exp0_res = 32'hEDCB_A987; exp0_err = 1'b0;
    rsp0_ready = 1'b0;
    step("rsthold_grant", 0);
    req0_valid = 1'b0;
    #2;
    chk("rsthold_valid_pre", {31'd0, rsp0_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rsthold_valid_async", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    chk("rsthold_result",      rsp_result, 32'd0);
    sb.delete();
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req1_valid = 1'b1; req1_opA = 32'hF0F0_F0F0; req1_opB = 32'hFF00_FF00; req1_opsel = 4'd2;
    exp1_res = 32'hF000_F000; exp1_err = 1'b0;
    step("postrst_grant", 1);
    chk("postrst_no_stale0", {31'd0, rsp0_valid}, 32'd0);
    req1_valid = 1'b0;
    step("postrst_drain", -1);
    step("postrst_idle", -1);
    chk("postrst_idle_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);

    chk("sb_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
